edca_backoff_sched: RTL and testbench

Per-access-category backoff scheduler for the XPU transmit path. Selects the highest-priority pending queue and steers `tx_queue_idx` so the contention-window exponent logic produces that queue's current `cw_exp`. It then draws a random backoff, waits AIFS and counts down idle slots, launching the transmission when the count reaches zero. It closes the retry loop by issuing `tx_try_complete`, `retrans_trigger` or `quit_retrans` pulses back to the CW exponent logic.

---
 rtl/edca_sched_pkg.sv | 40 ++++
 rtl/edca_backoff_sched_lfsr.sv | 28 ++
 rtl/edca_backoff_sched.sv | 212 +++++++++++++++++++++
 tb/tb_edca_backoff_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/edca_sched_pkg.sv
// Shared types and constants for the EDCA backoff scheduler.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package edca_sched_pkg;

  localparam int NUM_Q      = 4;
  localparam int CW_EXP_MAX = 10;
  localparam int BO_W       = 10;
  localparam int AIFSN_W    = 4;

  localparam logic [1:0] SETTLE_NEW   = 2'd3;
  localparam logic [1:0] SETTLE_RETRY = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DRAW,
    ST_AIFS,
    ST_BACKOFF,
    ST_TX,
    ST_RESOLVE
  } state_e;

  function automatic logic [1:0] top_q(input logic [NUM_Q-1:0] pend);
    logic [1:0] sel;
    sel = 2'd0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (pend[i]) sel = 2'(i);
    end
    return sel;
  endfunction

  // The exponent is clipped so the mask never exceeds the backoff counter width.
  function automatic logic [BO_W-1:0] bo_mask(input logic [3:0] cw);
    logic [3:0] e;
    e = (cw > 4'(CW_EXP_MAX)) ? 4'(CW_EXP_MAX) : cw;
    return ~({BO_W{1'b1}} << e);
  endfunction

endpackage

// File: rtl/edca_backoff_sched_lfsr.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) supplying backoff draws.
// Latency: advances every cycle; reset reloads SEED.
// Backpressure: none, never stalls.
module backoff_lfsr
  import edca_sched_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  output logic [BO_W-1:0] rnd
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign rnd = lfsr_q[BO_W-1:0];

endmodule

// File: rtl/edca_backoff_sched.sv
// EDCA per-AC backoff scheduler; EDCA_BACKOFF_PREEMPT_EN lets a higher AC abort a countdown.
// Latency: pend->idx 1 cycle, DRAW 4 cycles after pend, tx_start 1 cycle after final slot.
// Backpressure: holds in TX until tx_result_valid; busy channel freezes the countdown.
module edca_backoff_sched
  import edca_sched_pkg::*;
#(
  parameter int          RETRY_LIMIT = 7,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_Q-1:0]           tx_pend,
  input  logic [3:0]                 cw_exp,
  input  logic [NUM_Q*AIFSN_W-1:0]   aifsn_combined,
  input  logic                       slot_tick,
  input  logic                       ch_idle,
  input  logic                       tx_result_valid,
  input  logic                       tx_result_ack,
  output logic [1:0]                 tx_queue_idx,
  output logic                       tx_start,
  output logic                       tx_try_complete,
  output logic                       retrans_trigger,
  output logic                       quit_retrans,
  output logic                       sched_busy,
  output logic [BO_W-1:0]            bo_cnt,
  output logic [3:0]                 retry_cnt
);

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [1:0]            settle_q, settle_d;
  logic [AIFSN_W-1:0]    aifs_q, aifs_d;
  logic [BO_W-1:0]       bo_q, bo_d;
  logic [3:0]            retry_q, retry_d;
  logic                  ack_q, ack_d;
  logic                  start_q, start_d;
  logic                  complete_q, complete_d;
  logic                  retrans_q, retrans_d;
  logic                  quit_q, quit_d;

  logic [BO_W-1:0]       rnd;
  logic [AIFSN_W-1:0]    aifs_raw;
  logic [AIFSN_W-1:0]    aifs_load;
  logic                  pend_sel;
  logic                  contending;

  backoff_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .rnd (rnd)
  );

  always_comb begin
    aifs_raw   = aifsn_combined[{idx_q, 2'b00} +: AIFSN_W];
    aifs_load  = (aifs_raw == '0) ? AIFSN_W'(1) : aifs_raw;
    pend_sel   = tx_pend[idx_q];
    contending = (state_q == ST_SETTLE) || (state_q == ST_DRAW) ||
                 (state_q == ST_AIFS)   || (state_q == ST_BACKOFF);
  end

`ifdef EDCA_BACKOFF_PREEMPT_EN
  logic [NUM_Q-1:0] above_mask;
  logic             higher;

  always_comb begin
    above_mask = ~((4'd2 << idx_q) - 4'd1);
    higher     = |(tx_pend & above_mask);
  end
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    aifs_d     = aifs_q;
    bo_d       = bo_q;
    retry_d    = retry_q;
    ack_d      = ack_q;
    start_d    = 1'b0;
    complete_d = 1'b0;
    retrans_d  = 1'b0;
    quit_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|tx_pend) begin
          idx_d    = top_q(tx_pend);
          retry_d  = '0;
          settle_d = SETTLE_NEW;
          state_d  = ST_SETTLE;
        end
      end
      // Waits out the CW exponent logic so cw_exp reflects the selected queue.
      ST_SETTLE: begin
        settle_d = settle_q - 2'd1;
        if (settle_q == 2'd1) state_d = ST_DRAW;
      end
      ST_DRAW: begin
        bo_d    = rnd & bo_mask(cw_exp);
        aifs_d  = aifs_load;
        state_d = ST_AIFS;
      end
      ST_AIFS: begin
        if (!ch_idle) begin
          aifs_d = aifs_load;
        end else if (slot_tick) begin
          aifs_d = aifs_q - AIFSN_W'(1);
          if (aifs_q == AIFSN_W'(1)) begin
            if (bo_q == '0) begin
              state_d = ST_TX;
              start_d = 1'b1;
            end else begin
              state_d = ST_BACKOFF;
            end
          end
        end
      end
      ST_BACKOFF: begin
        if (!ch_idle) begin
          aifs_d  = aifs_load;
          state_d = ST_AIFS;
        end else if (slot_tick) begin
          bo_d = bo_q - BO_W'(1);
          if (bo_q == BO_W'(1)) begin
            state_d = ST_TX;
            start_d = 1'b1;
          end
        end
      end
      ST_TX: begin
        if (tx_result_valid) begin
          ack_d   = tx_result_ack;
          state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        if (ack_q) begin
          complete_d = 1'b1;
          retry_d    = '0;
          state_d    = ST_IDLE;
        end else if (retry_q < 4'(RETRY_LIMIT)) begin
          retry_d   = retry_q + 4'd1;
          retrans_d = 1'b1;
          settle_d  = SETTLE_RETRY;
          state_d   = ST_SETTLE;
        end else begin
          quit_d  = 1'b1;
          retry_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Withdrawal outranks everything else while contending; TX is committed.
    if (contending && !pend_sel) begin
      quit_d  = 1'b1;
      retry_d = '0;
      start_d = 1'b0;
      state_d = ST_IDLE;
    end
`ifdef EDCA_BACKOFF_PREEMPT_EN
    else if (((state_q == ST_AIFS) || (state_q == ST_BACKOFF)) && higher) begin
      quit_d   = 1'b1;
      retry_d  = '0;
      start_d  = 1'b0;
      bo_d     = '0;
      idx_d    = top_q(tx_pend);
      settle_d = SETTLE_NEW;
      state_d  = ST_SETTLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      settle_q   <= '0;
      aifs_q     <= '0;
      bo_q       <= '0;
      retry_q    <= '0;
      ack_q      <= 1'b0;
      start_q    <= 1'b0;
      complete_q <= 1'b0;
      retrans_q  <= 1'b0;
      quit_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      aifs_q     <= aifs_d;
      bo_q       <= bo_d;
      retry_q    <= retry_d;
      ack_q      <= ack_d;
      start_q    <= start_d;
      complete_q <= complete_d;
      retrans_q  <= retrans_d;
      quit_q     <= quit_d;
    end
  end

  assign tx_queue_idx    = idx_q;
  assign tx_start        = start_q;
  assign tx_try_complete = complete_q;
  assign retrans_trigger = retrans_q;
  assign quit_retrans    = quit_q;
  assign sched_busy      = (state_q != ST_IDLE);
  assign bo_cnt          = bo_q;
  assign retry_cnt       = retry_q;

endmodule

// File: tb/tb_edca_backoff_sched.sv
// Scoreboard bench for edca_backoff_sched; pulses are matched against queued expectations.
// Latency: expected pulse cycles are computed from the driven slot/result timing.
// Backpressure: none; the bench drives results directly.
module tb_edca_backoff_sched;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int K_START = 0, K_COMPLETE = 1, K_RETRANS = 2, K_QUIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  tx_pend = '0;
  logic [3:0]  cw_exp = '0;
  logic [15:0] aifsn_combined = 16'h3250;
  logic        slot_tick = 1'b0;
  logic        ch_idle = 1'b1;
  logic        tx_result_valid = 1'b0;
  logic        tx_result_ack = 1'b0;
  logic [1:0]  tx_queue_idx;
  logic        tx_start, tx_try_complete, retrans_trigger, quit_retrans, sched_busy;
  logic [9:0]  bo_cnt;
  logic [3:0]  retry_cnt;

  edca_backoff_sched #(.RETRY_LIMIT(7), .LFSR_SEED(SEED)) dut (
    .clk             (clk),
    .rst             (rst),
    .tx_pend         (tx_pend),
    .cw_exp          (cw_exp),
    .aifsn_combined  (aifsn_combined),
    .slot_tick       (slot_tick),
    .ch_idle         (ch_idle),
    .tx_result_valid (tx_result_valid),
    .tx_result_ack   (tx_result_ack),
    .tx_queue_idx    (tx_queue_idx),
    .tx_start        (tx_start),
    .tx_try_complete (tx_try_complete),
    .retrans_trigger (retrans_trigger),
    .quit_retrans    (quit_retrans),
    .sched_busy      (sched_busy),
    .bo_cnt          (bo_cnt),
    .retry_cnt       (retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int cyc;
    int idx;
    int retry;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        ev;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lf_next(input logic [15:0] x);
    logic fb;
    fb = x[0];
    return {1'b0, x[15:1]} ^ {fb, 1'b0, fb, fb, 1'b0, fb, 10'b0};
  endfunction

  function automatic logic [15:0] adv(input logic [15:0] x, input int n);
    logic [15:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = lf_next(y);
    return y;
  endfunction

  function automatic int exp_bo(input logic [15:0] m, input int cw);
    int e;
    e = (cw > 10) ? 10 : cw;
    return int'(m & 16'h03FF) % (1 << e);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lf_next(m_lfsr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input int expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int idx, input int retry);
    exp_t e;
    e.kind = kind; e.cyc = c; e.idx = idx; e.retry = retry;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n, input logic idle);
    for (int i = 0; i < n; i++) begin
      ch_idle = idle;
      slot_tick = 1'b1;
      step(1);
      slot_tick = 1'b0;
      step(1);
    end
  endtask

  // Idle slots ending in a launch one cycle after the last tick.
  task automatic countdown(input int n, input int idx, input int retry);
    for (int i = 0; i < n; i++) begin
      ch_idle = 1'b1;
      slot_tick = 1'b1;
      if (i == n - 1) push(K_START, cyc + 1, idx, retry);
      step(1);
      slot_tick = 1'b0;
      step(1);
    end
  endtask

  task automatic resolve(input logic ack, input int kind, input int idx, input int retry,
                         input logic drop);
    tx_result_valid = 1'b1;
    tx_result_ack = ack;
    if (drop) tx_pend = '0;
    push(kind, cyc + 2, idx, retry);
    step(1);
    tx_result_valid = 1'b0;
    tx_result_ack = 1'b0;
  endtask

  // Raises pend once the draw four cycles ahead yields at least min_bo.
  task automatic start_frame(input logic [3:0] pend, input int idx, input int min_bo,
                             input int cw, output int bo);
    int guard;
    guard = 0;
    cw_exp = 4'(cw);
    while (exp_bo(adv(m_lfsr, 4), cw) < min_bo && guard < 300) begin
      step(1);
      guard++;
    end
    tx_pend = pend;
    step(1);
    chk("sel_idx", tx_queue_idx, idx);
    chk("busy_after_pend", sched_busy, 1);
    step(3);
    bo = exp_bo(m_lfsr, cw);
    step(1);
    chk("bo_draw", bo_cnt, bo);
  endtask

  always @(negedge clk) begin
    logic [3:0] p;
    p = {quit_retrans, retrans_trigger, tx_try_complete, tx_start};
    for (int k = 0; k < 4; k++) begin
      if (p[k] !== 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", k, -1);
        end else begin
          ev = exp_q.pop_front();
          chk("pulse_kind", k, ev.kind);
          chk("pulse_cycle", cyc, ev.cyc);
          chk("pulse_idx", tx_queue_idx, ev.idx);
          chk("pulse_retry", retry_cnt, ev.retry);
        end
      end
    end
  end

  initial begin
    int b;
    step(3);
    chk("reset_outputs", {tx_queue_idx, tx_start, tx_try_complete, retrans_trigger,
                          quit_retrans, sched_busy, bo_cnt, retry_cnt}, 0);
    rst = 1'b0;
    step(1);

    // Queue 2, cw 4, AIFSN 2: launch after 2 + bo slots, then ACK.
    start_frame(4'b0100, 2, 0, 4, b);
    countdown(2 + b, 2, 0);
    resolve(1'b1, K_COMPLETE, 2, 0, 1'b1);
    step(2);
    chk("idle_after_ack", sched_busy, 0);

    // Queue 1, AIFSN 5: busy channel at residue 5 freezes and redoes AIFS.
    start_frame(4'b0010, 1, 6, 10, b);
    ticks(b, 1'b1);
    chk("bo_residue", bo_cnt, 5);
    ticks(3, 1'b0);
    chk("bo_frozen", bo_cnt, 5);
    ch_idle = 1'b1;
    countdown(5 + 5, 1, 0);
    resolve(1'b1, K_COMPLETE, 1, 0, 1'b1);
    step(2);

    // Queue 3, AIFSN 3: cw 0 launches straight from AIFS; 7 retries then quit.
    start_frame(4'b1000, 3, 0, 0, b);
    countdown(3 + b, 3, 0);
    for (int i = 1; i <= 7; i++) begin
      cw_exp = 4'(i);
      resolve(1'b0, K_RETRANS, 3, i, 1'b0);
      step(2);
      b = exp_bo(m_lfsr, i);
      step(1);
      chk("bo_redraw", bo_cnt, b);
      countdown(3 + b, 3, i);
    end
    resolve(1'b0, K_QUIT, 3, 0, 1'b1);
    step(1);
    chk("retry_cleared", retry_cnt, 0);
    chk("idle_after_quit", sched_busy, 0);
    step(1);

    // cw 15 clips to a 10-bit draw; withdrawal in BACKOFF quits.
    start_frame(4'b0100, 2, 512, 15, b);
    ticks(2 + 3, 1'b1);
    chk("bo_wide_count", bo_cnt, b - 3);
    tx_pend = '0;
    push(K_QUIT, cyc + 1, 2, 0);
    step(2);
    chk("idle_after_withdraw", sched_busy, 0);

    // Higher-priority queue appears while queue 0 is in BACKOFF.
    start_frame(4'b0001, 0, 3, 3, b);
    ticks(1 + 1, 1'b1);
    tx_pend = 4'b1001;
`ifdef EDCA_BACKOFF_PREEMPT_EN
    push(K_QUIT, cyc + 1, 3, 0);
    step(1);
    chk("preempt_idx", tx_queue_idx, 3);
    tx_pend = '0;
    push(K_QUIT, cyc + 1, 3, 0);
    step(2);
`else
    countdown(b - 1, 0, 0);
    resolve(1'b1, K_COMPLETE, 0, 0, 1'b1);
    step(2);
`endif
    chk("idle_after_preempt_case", sched_busy, 0);

    // Reset during BACKOFF: outputs clear, no pulses, LFSR reseeded.
    start_frame(4'b0100, 2, 3, 4, b);
    ticks(2 + 1, 1'b1);
    rst = 1'b1;
    tx_pend = '0;
    step(1);
    chk("rst_mid_outputs", {tx_queue_idx, tx_start, tx_try_complete, retrans_trigger,
                            quit_retrans, sched_busy, bo_cnt, retry_cnt}, 0);
    rst = 1'b0;
    step(2);
    start_frame(4'b0100, 2, 0, 4, b);
    countdown(2 + b, 2, 0);
    resolve(1'b1, K_COMPLETE, 2, 0, 1'b1);

    for (int g = 0; g < 100 && exp_q.size() != 0; g++) step(1);
    chk("pending_events", exp_q.size(), 0);
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
